// File: rtl/pipe_stage_chain.sv
// Elastic chain of STAGES valid/ready pipeline registers with bubble collapse,
// per-stage flush, occupancy count and a saturating back-pressure stall counter.
module pipe_stage_chain #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  input  logic [STAGES-1:0]              flush_mask,
  input  logic                           clr_stats,
  output logic [$clog2(STAGES+1)-1:0]    occupancy,
  output logic [CNT_W-1:0]               stall_count
);

  localparam int OCC_W = $clog2(STAGES+1);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, while ready may depend on the far side.
  logic [STAGES-1:0]            r_v;
  logic [STAGES-1:0][WIDTH-1:0] r_d;
  logic [CNT_W-1:0]             r_stall;

  logic [STAGES-1:0]            w_rdy;
  logic [STAGES-1:0]            w_src_v;
  logic [STAGES-1:0][WIDTH-1:0] w_src_d;
  logic [OCC_W-1:0]             w_occ;

  // Stage i can load unless it and every stage after it are full while the
  // consumer stalls; written as a tail-AND to avoid a self-referencing chain.
  always_comb begin
    logic w_full_tail;
    w_rdy = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_full_tail = 1'b1;
      for (int j = i; j < STAGES; j++) begin
        w_full_tail = w_full_tail & r_v[j];
      end
      w_rdy[i] = out_ready | ~w_full_tail;
    end
  end

  // A flushed stage's item is dropped on its way out, not only where it sits.
  always_comb begin
    w_src_v    = '0;
    w_src_d    = '0;
    w_src_v[0] = in_valid;
    w_src_d[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      w_src_v[i] = r_v[i-1] & ~flush_mask[i-1];
      w_src_d[i] = r_d[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v     <= '0;
      r_d     <= '0;
      r_stall <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush_mask[i]) begin
          r_v[i] <= 1'b0;
        end else if (w_rdy[i]) begin
          r_v[i] <= w_src_v[i];
        end
        if (w_rdy[i] && w_src_v[i]) begin
          r_d[i] <= w_src_d[i];
        end
      end
      if (clr_stats) begin
        r_stall <= '0;
      end else if (r_v[STAGES-1] && !out_ready && !(&r_stall)) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ = w_occ + OCC_W'(r_v[i]);
    end
  end

  assign in_ready    = w_rdy[0];
  assign out_valid   = r_v[STAGES-1];
  assign out_data    = r_d[STAGES-1];
  assign occupancy   = w_occ;
  assign stall_count = r_stall;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed test-plan phases plus random traffic,
// checked against a queue-of-items reference model and an expected-data queue.
module tb_pipe_stage_chain;

  localparam int S  = 4;
  localparam int W  = 64;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [S-1:0]    flush_mask;
  logic            clr_stats;
  logic [2:0]      occupancy;
  logic [CW-1:0]   stall_count;

  int checks = 0;
  int errors = 0;

  pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush_mask(flush_mask), .clr_stats(clr_stats),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: live items oldest-first with their stage positions
  logic [W-1:0] m_data[$];
  int           m_pos[$];
  int           m_stall = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // An item advances if the slot ahead is free or its occupant advances too;
  // the oldest item at the exit advances only when the consumer takes it.
  function automatic logic [S-1:0] calc_moves(input logic ordy);
    logic [S-1:0] mv = '0;
    for (int k = 0; k < m_pos.size(); k++) begin
      if (k == 0) mv[k] = (m_pos[0] == S-1) ? ordy : 1'b1;
      else if (m_pos[k-1] == m_pos[k] + 1) mv[k] = mv[k-1];
      else mv[k] = 1'b1;
    end
    return mv;
  endfunction

  function automatic logic model_in_ready(input logic ordy);
    logic [S-1:0] mv;
    int n;
    mv = calc_moves(ordy);
    n = m_pos.size();
    return (n == 0) || (m_pos[n-1] != 0) || mv[n-1];
  endfunction

  function automatic logic model_out_valid();
    return (m_pos.size() > 0) && (m_pos[0] == S-1);
  endfunction

  function automatic void kill_exp(input logic [W-1:0] val);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i] == val) begin
        exp_q.delete(i);
        break;
      end
    end
  endfunction

  always @(posedge clk) begin
    logic [S-1:0] mv;
    logic         acc;
    logic [W-1:0] nd[$];
    int           np[$];
    int           p, q;
    logic         moved;
    if (reset) begin
      m_data.delete();
      m_pos.delete();
      exp_q.delete();
      m_stall = 0;
    end else begin
      mv  = calc_moves(out_ready);
      acc = in_valid && model_in_ready(out_ready);
      if (clr_stats) m_stall = 0;
      else if (model_out_valid() && !out_ready && m_stall < (1 << CW) - 1) m_stall++;
      nd.delete();
      np.delete();
      for (int k = 0; k < m_pos.size(); k++) begin
        p = m_pos[k];
        moved = mv[k];
        if (p == S-1 && moved) continue;  // retired this edge
        q = moved ? p + 1 : p;
        if (flush_mask[p] || (moved && flush_mask[q])) kill_exp(m_data[k]);
        else begin
          nd.push_back(m_data[k]);
          np.push_back(q);
        end
      end
      if (acc && !flush_mask[0]) begin
        nd.push_back(in_data);
        np.push_back(0);
        exp_q.push_back(in_data);
      end
      m_data = nd;
      m_pos  = np;
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    chk("in_ready",  {63'd0, in_ready},  {63'd0, model_in_ready(out_ready)});
    chk("out_valid", {63'd0, out_valid}, {63'd0, model_out_valid()});
    chk("occupancy", W'(occupancy), W'(m_pos.size()));
    chk("stall_count", W'(stall_count), W'(m_stall));
    if (out_valid && exp_q.size() > 0) chk("out_data_head", out_data, exp_q[0]);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", out_data, '1);
      else begin
        e = exp_q.pop_front();
        chk("retired_data", out_data, e);
      end
    end
  end

  // driver: data is held until accepted, as a well-behaved producer would
  int   seq = 0;
  logic offer_pending = 1'b0;
  logic took;

  task automatic drive(input logic rst, input logic iv, input logic ordy,
                       input logic [S-1:0] fm, input logic clr, input logic rnd_hi);
    if (!(offer_pending && iv)) begin
      seq++;
      in_data = {rnd_hi ? $urandom() : 32'h0, 32'(seq)};
    end
    reset = rst; in_valid = iv; out_ready = ordy; flush_mask = fm; clr_stats = clr;
    @(negedge clk);
    took = in_valid && in_ready;
    offer_pending = iv && !took && !rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush_mask = '0;
    clr_stats = 1'b0; in_data = '0;
    @(posedge clk); #1;
    drive(1, 0, 0, '0, 0, 0);
    chk("reset_out_data", out_data, '0);
    chk("reset_stall", W'(stall_count), '0);

    // stream with consumer always ready
    for (int i = 0; i < 10; i++) drive(0, 1, 1, '0, 0, 0);
    for (int i = 0; i < 5; i++)  drive(0, 0, 1, '0, 0, 0);

    // back-pressure fill, hold, release
    for (int i = 0; i < 6; i++) drive(0, 1, 0, '0, 0, 0);
    chk("bp_full_occ", W'(occupancy), W'(S));
    for (int i = 0; i < 3; i++) drive(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, i < 4, 1, '0, 0, 0);

    // bubble collapse: items at stage 3 and 0, then two stalled edges
    drive(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, '0, 0, 0);
    drive(0, 1, 0, '0, 0, 0);
    drive(0, 0, 0, '0, 0, 0);
    drive(0, 0, 0, '0, 0, 0);
    chk("bubble_occ", W'(occupancy), 64'd2);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, '0, 0, 0);

    // flush stages 0..2 while the exit item retires and a new item enters
    for (int i = 0; i < 4; i++) drive(0, 1, 0, '0, 0, 0);
    drive(0, 1, 1, 4'b0111, 0, 0);
    chk("flush_occ", W'(occupancy), '0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, '0, 0, 0);

    // saturation and clear
    for (int i = 0; i < 4; i++) drive(0, 1, 0, '0, 0, 0);
    drive(0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, '0, 0, 0);
    chk("stall_sat", W'(stall_count), 64'd15);
    drive(0, 0, 0, '0, 1, 0);
    chk("stall_clr", W'(stall_count), 64'd0);
    drive(0, 0, 0, '0, 0, 0);
    chk("stall_after_clr", W'(stall_count), 64'd1);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, '0, 0, 0);

    // reset mid-stream with three items in flight
    for (int i = 0; i < 3; i++) drive(0, 1, 0, '0, 0, 0);
    drive(1, 1, 0, '0, 0, 0);
    chk("mid_reset_valid", {63'd0, out_valid}, '0);
    chk("mid_reset_data", out_data, '0);
    chk("mid_reset_occ", W'(occupancy), '0);
    chk("mid_reset_stall", W'(stall_count), '0);
    chk("mid_reset_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, '0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0,
            ($urandom_range(0, 9) == 0) ? S'($urandom_range(0, (1 << S) - 1)) : '0,
            $urandom_range(0, 49) == 0,
            1);
    end

    for (int i = 0; i < 10; i++) drive(0, 0, 1, '0, 0, 0);
    chk("drain_empty", W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
